// File: rtl/mod_stream_reducer_if.sv
// Chunk-in / residue-out handshake bundle for the streaming modulo reducer.
// Both ports use valid/ready: a beat transfers on a rising clk edge where valid and ready are both 1.
interface mod_stream_reducer_if #(
    parameter int CHUNK_W = 6,
    parameter int RES_W   = 8,
    parameter int CNT_W   = 7
) ();
    logic               in_valid;
    logic               in_ready;
    logic [CHUNK_W-1:0] in_data;
    logic               in_last;
    logic               res_valid;
    logic               res_ready;
    logic [RES_W-1:0]   res_data;
    logic               res_err;
    logic [CNT_W-1:0]   res_chunks;

    modport master (
        output in_valid, in_data, in_last, res_ready,
        input  in_ready, res_valid, res_data, res_err, res_chunks
    );

    modport slave (
        input  in_valid, in_data, in_last, res_ready,
        output in_ready, res_valid, res_data, res_err, res_chunks
    );
endinterface

// File: rtl/mod_stream_reducer.sv
// Horner-style reduction of a chunk stream (MS chunk first) modulo MODULUS, one chunk per clock,
// with the residue, chunk count and truncation flag presented on a valid/ready result port.
module mod_stream_reducer #(
    parameter int MODULUS    = 241,
    parameter int CHUNK_W    = 6,
    parameter int RES_W      = 8,
    parameter int MAX_CHUNKS = 84,
    parameter int CNT_W      = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    mod_stream_reducer_if.slave bus,
    output logic [1:0]          dbg_state
);
    localparam int W = RES_W + CHUNK_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [RES_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     red;
    logic [RES_W-1:0] red_res;
    logic             accept;
    logic             term;

    // acc < MODULUS keeps t below MODULUS*2^CHUNK_W, so CHUNK_W shifted subtractions fully reduce it.
    always_comb begin
        red = {acc, bus.in_data};
        for (int k = CHUNK_W - 1; k >= 0; k--) begin
            if (red >= (W'(MODULUS) << k)) begin
                red = red - (W'(MODULUS) << k);
            end
        end
    end

    assign red_res   = RES_W'(red);
    assign accept    = bus.in_valid & bus.in_ready;
    assign term      = accept & (bus.in_last | (cnt == CNT_W'(MAX_CHUNKS - 1)));
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            acc            <= '0;
            cnt            <= '0;
            bus.in_ready   <= 1'b1;
            bus.res_valid  <= 1'b0;
            bus.res_data   <= '0;
            bus.res_err    <= 1'b0;
            bus.res_chunks <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= red_res;
                        cnt <= cnt + CNT_W'(1);
                        if (term) begin
                            state          <= DONE;
                            bus.in_ready   <= 1'b0;
                            bus.res_valid  <= 1'b1;
                            bus.res_data   <= red_res;
                            bus.res_chunks <= cnt + CNT_W'(1);
                            // Ending without in_last means the operand was cut at MAX_CHUNKS.
                            bus.res_err    <= ~bus.in_last;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state         <= IDLE;
                        bus.res_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        acc           <= '0;
                        cnt           <= '0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mod_stream_reducer.sv
// Self-checking bench for mod_stream_reducer: fixed vectors, random operands against a wide-integer
// modulo model, truncation, result back-pressure and asynchronous reset mid-operand.
module tb_mod_stream_reducer;
    localparam int M    = 241;
    localparam int CW   = 6;
    localparam int RW   = 8;
    localparam int MC   = 84;
    localparam int CNTW = 7;
    localparam int TMO  = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    mod_stream_reducer_if #(.CHUNK_W(CW), .RES_W(RW), .CNT_W(CNTW)) bus ();

    mod_stream_reducer #(
        .MODULUS(M), .CHUNK_W(CW), .RES_W(RW), .MAX_CHUNKS(MC), .CNT_W(CNTW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_fail = 0;
    logic [RW-1:0] exp_q[$];

    typedef struct {
        int           n;
        logic [511:0] val;
        logic [RW-1:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    // Reference: the whole operand as one wide integer, reduced with a plain modulo.
    function automatic logic [RW-1:0] ref_mod(input logic [511:0] v);
        logic [511:0] r;
        r = v % 512'(M);
        return r[RW-1:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one chunk and return #1 after the edge that accepted it.
    task automatic push_chunk(input logic [CW-1:0] d, input logic last, input bit gaps);
        int t;
        t = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) begin
            n_checks++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic take_result(input int delay, input logic [RW-1:0] e);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("hold_valid", bus.res_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_data", bus.res_data, e);
        end
        @(negedge clk);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        chk("valid_drop", bus.res_valid, 0);
        chk("in_ready_back", bus.in_ready, 1);
    endtask

    task automatic run_operand(input logic [511:0] v, input int n, input bit gaps, input int delay);
        logic [RW-1:0] e;
        for (int i = n - 1; i >= 0; i--) begin
            push_chunk(v[i*CW +: CW], (i == 0), gaps);
        end
        e = exp_q.pop_front();
        chk("latency_valid", bus.res_valid, 1);
        chk("res_data", bus.res_data, e);
        chk("res_chunks", bus.res_chunks, n);
        chk("res_err", bus.res_err, 0);
        take_result(delay, e);
    endtask

    initial begin
        logic [511:0]  v;
        logic [CW-1:0] d85;
        logic [RW-1:0] e;
        int            n;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;

        tbl[0].n = 1;  tbl[0].val = 512'd63;   tbl[0].exp_data = 8'd63;
        tbl[1].n = 2;  tbl[1].val = 512'd4095; tbl[1].exp_data = 8'd239;
        tbl[2].n = 2;  tbl[2].val = 512'd241;  tbl[2].exp_data = 8'd0;
        tbl[3].n = 84; tbl[3].val = (512'd1 << 500) - 512'd1; tbl[3].exp_data = ref_mod(tbl[3].val);
        tbl[4].n = 84; tbl[4].val = (512'd1 << 502) - 512'd1; tbl[4].exp_data = ref_mod(tbl[4].val);

        #1 rst_n = 1'b0;
        #3;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_err", bus.res_err, 0);
        chk("rst_res_chunks", bus.res_chunks, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(tbl[i].exp_data);
            run_operand(tbl[i].val, tbl[i].n, 1'b0, 0);
        end

        for (int r = 0; r < 16; r++) begin
            n = (r < 2) ? MC : $urandom_range(1, MC);
            v = '0;
            for (int j = 0; j < n; j++) v = (v << CW) | 512'($urandom_range(0, 63));
            exp_q.push_back(ref_mod(v));
            run_operand(v, n, 1'b1, $urandom_range(0, 3));
        end

        // Oversized operand: cut at MAX_CHUNKS, then the 85th chunk is held off until the result is taken.
        v = '0;
        for (int j = 0; j < MC; j++) v = (v << CW) | 512'($urandom_range(0, 63));
        e = ref_mod(v);
        d85 = CW'($urandom_range(1, 63));
        for (int i = MC - 1; i >= 0; i--) push_chunk(v[i*CW +: CW], 1'b0, 1'b0);
        chk("trunc_valid", bus.res_valid, 1);
        chk("trunc_err", bus.res_err, 1);
        chk("trunc_chunks", bus.res_chunks, MC);
        chk("trunc_data", bus.res_data, e);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d85;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", bus.res_valid, 1);
            chk("bp_data", bus.res_data, e);
            chk("bp_err", bus.res_err, 1);
            chk("bp_chunks", bus.res_chunks, MC);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        chk("bp_release_valid", bus.res_valid, 0);
        chk("bp_release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("after_trunc_valid", bus.res_valid, 1);
        chk("after_trunc_data", bus.res_data, d85);
        chk("after_trunc_chunks", bus.res_chunks, 1);
        chk("after_trunc_err", bus.res_err, 0);
        take_result(0, d85);

        // Asynchronous reset in the middle of an operand.
        for (int i = 0; i < 10; i++) push_chunk(CW'($urandom_range(0, 63)), 1'b0, 1'b0);
        chk("mid_state", dbg_state, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_res_valid", bus.res_valid, 0);
        chk("arst_res_data", bus.res_data, 0);
        chk("arst_res_err", bus.res_err, 0);
        chk("arst_res_chunks", bus.res_chunks, 0);
        chk("arst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'd5);
        run_operand(512'd5, 2, 1'b0, 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
